// File: rtl/sum_reduce.sv
// Multi-cycle tree reduction (sum or unsigned max) of N_IN operands.
// Up to NUM_ADD pairs are combined per clock until a single value remains.
module sum_reduce #(
  parameter int N_IN    = 7,
  parameter int IN_W    = 10,
  parameter int NUM_ADD = 2,
  // $clog2(1) is 0, so a single operand keeps OUT_W at IN_W
  localparam int OUT_W  = IN_W + $clog2(N_IN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r_enable,
  input  logic [N_IN*IN_W-1:0] init_data,
  input  logic                 mode,
  output logic                 busy,
  output logic                 w_enable,
  output logic [OUT_W-1:0]     result
);

  localparam int CNT_W = $clog2(N_IN + 1);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OUT_W-1:0] r_slot      [N_IN];
  logic [OUT_W-1:0] w_slot_nxt  [N_IN];
  logic [OUT_W-1:0] w_comb      [N_IN];
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_mode;
  logic             w_done;
  int               w_k;

  // Combine unit u pairs slots 2u and 2u+1; units that cannot exist read as zero
  for (genvar u = 0; u < N_IN; u++) begin : g_unit
    if (u < NUM_ADD && 2 * u + 1 < N_IN) begin : g_live
      logic [OUT_W-1:0] w_a;
      logic [OUT_W-1:0] w_b;
      assign w_a       = r_slot[2*u];
      assign w_b       = r_slot[2*u+1];
      assign w_comb[u] = r_mode ? ((w_a > w_b) ? w_a : w_b) : (w_a + w_b);
    end else begin : g_dead
      assign w_comb[u] = '0;
    end
  end

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    w_k = (int'(r_count) / 2 < NUM_ADD) ? int'(r_count) / 2 : NUM_ADD;
    for (int i = 0; i < N_IN; i++) begin
      w_slot_nxt[i] = r_slot[i];
      if (i < w_k) begin
        w_slot_nxt[i] = w_comb[i];
      end else if (i + w_k < N_IN) begin
        w_slot_nxt[i] = r_slot[i+w_k];
      end
    end
    w_count_nxt = r_count - CNT_W'(w_k);
    w_done      = (w_count_nxt == CNT_W'(1));
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_enable) begin
      w_state_nxt = REDUCE;
    end else if (r_state == REDUCE && w_done) begin
      w_state_nxt = DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the operand slots carry no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    if (r_enable) begin
      for (int i = 0; i < N_IN; i++) begin
        r_slot[i] <= OUT_W'(init_data[i*IN_W +: IN_W]);
      end
    end else if (r_state == REDUCE) begin
      r_slot <= w_slot_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_mode   <= 1'b0;
      w_enable <= 1'b0;
      result   <= '0;
    end else if (r_enable) begin
      r_count  <= CNT_W'(N_IN);
      r_mode   <= mode;
      w_enable <= 1'b0;
    end else if (r_state == REDUCE) begin
      r_count <= w_count_nxt;
      if (w_done) begin
        result   <= w_slot_nxt[0];
        w_enable <= 1'b1;
      end
    end
  end

  assign busy = (r_state == REDUCE);

endmodule

// File: tb/tb_sum_reduce.sv
// Directed bench for sum_reduce: default build plus NUM_ADD=4 and N_IN=1 builds
// sharing clock, reset, start and mode.
module tb_sum_reduce;

  logic        clk;
  logic        rst_n;
  logic        r_enable;
  logic        mode;
  logic [69:0] data7;
  logic [9:0]  data1;

  logic        busy_a, wen_a;
  logic [12:0] res_a;
  logic        busy_b, wen_b;
  logic [12:0] res_b;
  logic        busy_c, wen_c;
  logic [9:0]  res_c;

  int errors = 0;
  int checks = 0;
  int edges;
  int busy_cnt;

  sum_reduce u_dut (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .init_data(data7), .mode(mode),
    .busy(busy_a), .w_enable(wen_a), .result(res_a)
  );

  sum_reduce #(.NUM_ADD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .init_data(data7), .mode(mode),
    .busy(busy_b), .w_enable(wen_b), .result(res_b)
  );

  sum_reduce #(.N_IN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .init_data(data1), .mode(mode),
    .busy(busy_c), .w_enable(wen_c), .result(res_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start over one rising edge, then scramble inputs to prove they were latched
  task automatic start();
    @(negedge clk);
    r_enable = 1'b1;
    @(negedge clk);
    r_enable = 1'b0;
    data7    = 70'({$urandom(), $urandom(), $urandom()});
    data1    = 10'($urandom());
    mode     = ~mode;
  endtask

  // Count edges after the start edge until u_dut raises w_enable (bounded)
  task automatic wait_done(output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = 0;
    while (!wen_a && n_edges < 20) begin
      if (busy_a) n_busy++;
      @(negedge clk);
      n_edges++;
    end
  endtask

  task automatic load_seq();
    for (int i = 0; i < 7; i++) data7[i*10 +: 10] = 10'(i + 1);
  endtask

  initial begin
    int vals[7];
    vals     = '{5, 900, 3, 900, 17, 0, 1};
    rst_n    = 1'b0;
    r_enable = 1'b0;
    mode     = 1'b0;
    data7    = '0;
    data1    = '0;

    #1;
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_wen", 32'(wen_a), 32'd0);
    check("reset_result", 32'(res_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy_a), 32'd0);

    // Sum of 1..7
    load_seq();
    mode = 1'b0;
    start();
    wait_done(edges, busy_cnt);
    check("sum7_latency", 32'(edges), 32'd4);
    check("sum7_busy_cycles", 32'(busy_cnt), 32'd4);
    check("sum7_result", 32'(res_a), 32'd28);
    check("sum7_busy_low", 32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    check("done_hold_wen", 32'(wen_a), 32'd1);
    check("done_hold_result", 32'(res_a), 32'd28);

    // All operands at maximum value
    for (int i = 0; i < 7; i++) data7[i*10 +: 10] = 10'd1023;
    mode = 1'b0;
    start();
    check("restart_clears_wen", 32'(wen_a), 32'd0);
    wait_done(edges, busy_cnt);
    check("full_latency", 32'(edges), 32'd4);
    check("full_result", 32'(res_a), 32'd7161);

    // Maximum mode
    for (int i = 0; i < 7; i++) data7[i*10 +: 10] = 10'(vals[i]);
    mode = 1'b1;
    start();
    wait_done(edges, busy_cnt);
    check("max_latency", 32'(edges), 32'd4);
    check("max_result", 32'(res_a), 32'd900);

    // NUM_ADD=4 and N_IN=1 builds alongside the default build
    load_seq();
    data1 = 10'd9;
    mode  = 1'b0;
    start();
    check("n1_wen_edge0", 32'(wen_c), 32'd0);
    @(negedge clk);
    check("n1_wen_edge1", 32'(wen_c), 32'd1);
    check("n1_result", 32'(res_c), 32'd9);
    check("na4_wen_edge1", 32'(wen_b), 32'd0);
    @(negedge clk);
    check("na4_wen_edge2", 32'(wen_b), 32'd0);
    @(negedge clk);
    check("na4_wen_edge3", 32'(wen_b), 32'd1);
    check("na4_result", 32'(res_b), 32'd28);
    check("na2_wen_edge3", 32'(wen_a), 32'd0);
    @(negedge clk);
    check("na2_wen_edge4", 32'(wen_a), 32'd1);
    check("na2_result", 32'(res_a), 32'd28);

    // Restart at edge 2 aborts the first job
    load_seq();
    mode = 1'b0;
    start();
    @(negedge clk);
    check("abort_wen_edge1", 32'(wen_a), 32'd0);
    for (int i = 0; i < 7; i++) data7[i*10 +: 10] = 10'd2;
    mode     = 1'b0;
    r_enable = 1'b1;
    @(negedge clk);
    r_enable = 1'b0;
    data7    = '1;
    mode     = 1'b1;
    check("abort_busy_edge2", 32'(busy_a), 32'd1);
    for (int e = 3; e <= 5; e++) begin
      @(negedge clk);
      check($sformatf("abort_wen_edge%0d", e), 32'(wen_a), 32'd0);
    end
    @(negedge clk);
    check("abort_wen_edge6", 32'(wen_a), 32'd1);
    check("abort_result", 32'(res_a), 32'd14);

    // Asynchronous reset in the middle of a reduction
    load_seq();
    mode = 1'b0;
    start();
    @(negedge clk);
    check("pre_reset_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wen", 32'(wen_a), 32'd0);
    check("async_rst_busy", 32'(busy_a), 32'd0);
    check("async_rst_result", 32'(res_a), 32'd0);
    #1 rst_n = 1'b1;
    busy_cnt = 0;
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      if (busy_a || wen_a || res_a != 13'd0) busy_cnt++;
    end
    check("post_reset_idle", 32'(busy_cnt), 32'd0);

    load_seq();
    mode = 1'b0;
    start();
    wait_done(edges, busy_cnt);
    check("recover_latency", 32'(edges), 32'd4);
    check("recover_result", 32'(res_a), 32'd28);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
